ex_issue_arbiter: RTL and testbench
===================================

EX_ISSUE_ARBITER -- requirements
Module: ex_issue_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Ready_Ex  input  4  bit i set means operand-collector entry i holds a fully collected, valid instruction.
REQ-006 IsMem_Ex  input  4  bit i set means entry i is a load or store (MemRead|MemWrite); clear means ALU class, including branches.
REQ-007 ALU_Stall  input  1  ALU cannot accept an instruction this cycle.
REQ-008 MEM_Done  input  1  single-cycle pulse: the in-flight memory operation has completed.
REQ-009 ALU_Grt  output  4  one-hot or zero select into the ALU operand mux.
REQ-010 MEM_Grt  output  4  one-hot or zero select into the MEM operand mux.
REQ-011 Release_Ex  output  4  single-cycle pulse that frees collector entry i; equals ALU_Grt|MEM_Grt.
REQ-012 Mem_Busy  output  1  memory unit is occupied (FSM is in MEM_BUSY).

Function
REQ-013 ALU candidates SHALL be Ready_Ex & ~IsMem_Ex & ~Release_Ex; MEM candidates SHALL be Ready_Ex & IsMem_Ex & ~Release_Ex, so an entry granted last cycle is never re-granted.
REQ-014 Grants SHALL be registered: candidates sampled in cycle N produce grants held for exactly cycle N+1, then deasserted unless re-granted.
REQ-015 Each unit SHALL use its own round-robin pointer (2 bits, reset 0); the search order SHALL be ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-016 After granting entry k, that unit's pointer SHALL become (k+1) mod 4, wrapping 3->0; with no grant the pointer SHALL hold.
REQ-017 No ALU grant SHALL issue while ALU_Stall=1; that pointer SHALL hold.
REQ-018 The MEM FSM SHALL have states MEM_IDLE and MEM_BUSY.
REQ-019 A MEM grant SHALL be allowed in MEM_IDLE, or in MEM_BUSY in the cycle MEM_Done=1.
REQ-020 Issuing a MEM grant SHALL enter MEM_BUSY; MEM_Done with no new grant SHALL return the FSM to MEM_IDLE.
REQ-021 MEM_Done in MEM_IDLE SHALL be ignored.
REQ-022 ALU and MEM grants to different entries in the same cycle SHALL be permitted; ALU_Grt & MEM_Grt SHALL always be 0.
REQ-023 Mem_Busy SHALL equal (state==MEM_BUSY).

Reset
REQ-024 On rst the following SHALL clear to 0 asynchronously: ALU_Grt, MEM_Grt, Release_Ex, both pointers and all counters; the FSM SHALL go to MEM_IDLE and Mem_Busy to 0.
REQ-025 Reset asserted during MEM_BUSY SHALL abandon the in-flight operation; a subsequent MEM_Done SHALL be ignored.

Configuration
REQ-026 With ISSUE_PERF_CNT_EN defined, the block SHALL add outputs Alu_Issue_Cnt, Mem_Issue_Cnt and Mem_Stall_Cnt, each CNT_W bits and saturating at all-ones.
REQ-027 Mem_Stall_Cnt SHALL count cycles in which a MEM candidate exists but no MEM grant can issue.
REQ-028 Without ISSUE_PERF_CNT_EN, these counters and ports SHALL be absent and function SHALL be unchanged.

Structure
REQ-029 Shared package ex_issue_pkg SHALL hold NUM_OC=4, the mem_state_t enum {MEM_IDLE, MEM_BUSY} and the default counter width.
REQ-030 A combinational sub-module rr_arb4 (request[4], ptr[2] -> one-hot grant[4]) SHALL be instantiated twice, once for ALU and once for MEM.

Verification
REQ-031 After reset, Ready_Ex=4'b1111 and IsMem_Ex=0 held -> ALU_Grt sequence 0001, 0010, 0100, 1000, 0001 with no repeat on consecutive cycles.
REQ-032 Ready_Ex=4'b0101 and IsMem_Ex=4'b0100 -> next cycle ALU_Grt=0001 and MEM_Grt=0100 together, and Mem_Busy=1 the cycle after.
REQ-033 In MEM_BUSY with a MEM candidate on entry 2 -> MEM_Grt stays 0; a MEM_Done pulse -> MEM_Grt=0100 next cycle and Mem_Busy stays 1.
REQ-034 ALU_Stall=1 for 3 cycles with entry 3 ready -> ALU_Grt=0 throughout; stall released -> ALU_Grt=1000, then pointer=0.
REQ-035 rst pulsed mid-MEM_BUSY, then MEM_Done -> FSM stays MEM_IDLE, all outputs 0, and the next MEM candidate is granted one cycle after sampling.
REQ-036 With ISSUE_PERF_CNT_EN, 5 stalled MEM-candidate cycles -> Mem_Stall_Cnt=5; with CNT_W=4 and 20 ALU issues -> Alu_Issue_Cnt=15 (saturated).

Source files
------------

// File: rtl/ex_issue_pkg.sv
// Shared definitions for the execute-stage issue arbiter.
//   NUM_OC     : number of operand-collector entries
//   CNT_W_DEF  : default width of the optional performance counters
//   mem_state_t: memory-unit occupancy FSM encoding
package ex_issue_pkg;

  localparam int unsigned NUM_OC    = 4;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  // Index of the set bit in a one-hot 4-bit vector (0 when the vector is zero).
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_OC-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      if (v[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ex_issue_arbiter_if.sv
// Issue bus between the operand collector and the execute-stage arbiter.
//   master : operand collector (drives Ready_Ex/IsMem_Ex/ALU_Stall/MEM_Done)
//   slave  : ex_issue_arbiter (drives grants, releases, Mem_Busy, counters)
// Optional macro ISSUE_PERF_CNT_EN adds the performance counter signals.
interface ex_issue_arbiter_if
  import ex_issue_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic [NUM_OC-1:0] Ready_Ex;
  logic [NUM_OC-1:0] IsMem_Ex;
  logic              ALU_Stall;
  logic              MEM_Done;
  logic [NUM_OC-1:0] ALU_Grt;
  logic [NUM_OC-1:0] MEM_Grt;
  logic [NUM_OC-1:0] Release_Ex;
  logic              Mem_Busy;
`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0]  Alu_Issue_Cnt;
  logic [CNT_W-1:0]  Mem_Issue_Cnt;
  logic [CNT_W-1:0]  Mem_Stall_Cnt;
`endif

  modport master (
    output Ready_Ex, IsMem_Ex, ALU_Stall, MEM_Done,
`ifdef ISSUE_PERF_CNT_EN
    input  Alu_Issue_Cnt, Mem_Issue_Cnt, Mem_Stall_Cnt,
`endif
    input  ALU_Grt, MEM_Grt, Release_Ex, Mem_Busy
  );

  modport slave (
    input  Ready_Ex, IsMem_Ex, ALU_Stall, MEM_Done,
`ifdef ISSUE_PERF_CNT_EN
    output Alu_Issue_Cnt, Mem_Issue_Cnt, Mem_Stall_Cnt,
`endif
    output ALU_Grt, MEM_Grt, Release_Ex, Mem_Busy
  );

endinterface

// File: rtl/ex_issue_arbiter_rr_arb4.sv
// Combinational 4-way round-robin arbiter.
//   request : requesting entries
//   ptr     : highest-priority entry; search order ptr, ptr+1, ptr+2, ptr+3
//   grant   : one-hot winner, or zero when nothing requests
module rr_arb4
  import ex_issue_pkg::*;
(
  input  logic [NUM_OC-1:0] request,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_OC-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      idx = PTR_W'(ptr + PTR_W'(i));
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_issue_arbiter.sv
// Execute-stage issue arbiter: picks one ALU and one MEM instruction per cycle
// from the operand collector with independent round-robin pointers, and tracks
// memory-unit occupancy with a two-state FSM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ex_issue_arbiter_if.slave (ready/class/stall/done in; grants,
//              releases, Mem_Busy and optional counters out)
// Optional macro ISSUE_PERF_CNT_EN adds saturating issue/stall counters.
module ex_issue_arbiter
  import ex_issue_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  ex_issue_arbiter_if.slave   bus
);

  mem_state_t        state, state_nxt;
  logic [PTR_W-1:0]  alu_ptr, mem_ptr;
  logic [NUM_OC-1:0] alu_cand_c, mem_cand_c;
  logic [NUM_OC-1:0] alu_req_c, mem_req_c;
  logic [NUM_OC-1:0] alu_gnt_c, mem_gnt_c;
  logic              mem_allow_c;

  // Entries released last cycle are masked so they are never granted twice.
  assign alu_cand_c  = bus.Ready_Ex & ~bus.IsMem_Ex & ~bus.Release_Ex;
  assign mem_cand_c  = bus.Ready_Ex &  bus.IsMem_Ex & ~bus.Release_Ex;
  assign mem_allow_c = (state == MEM_IDLE) || bus.MEM_Done;
  assign alu_req_c   = bus.ALU_Stall ? '0 : alu_cand_c;
  assign mem_req_c   = mem_allow_c ? mem_cand_c : '0;

  rr_arb4 u_alu_arb (.request(alu_req_c), .ptr(alu_ptr), .grant(alu_gnt_c));
  rr_arb4 u_mem_arb (.request(mem_req_c), .ptr(mem_ptr), .grant(mem_gnt_c));

  // Memory FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  // Memory FSM next state; a grant in the MEM_Done cycle keeps the unit busy.
  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (|mem_gnt_c) state_nxt = MEM_BUSY;
      MEM_BUSY: if (bus.MEM_Done && !(|mem_gnt_c)) state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  assign bus.Mem_Busy = (state == MEM_BUSY);

  // Registered grants and round-robin pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ALU_Grt    <= '0;
      bus.MEM_Grt    <= '0;
      bus.Release_Ex <= '0;
      alu_ptr        <= '0;
      mem_ptr        <= '0;
    end else begin
      bus.ALU_Grt    <= alu_gnt_c;
      bus.MEM_Grt    <= mem_gnt_c;
      bus.Release_Ex <= alu_gnt_c | mem_gnt_c;
      if (|alu_gnt_c) alu_ptr <= PTR_W'(onehot_idx(alu_gnt_c) + PTR_W'(1));
      if (|mem_gnt_c) mem_ptr <= PTR_W'(onehot_idx(mem_gnt_c) + PTR_W'(1));
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Alu_Issue_Cnt <= '0;
      bus.Mem_Issue_Cnt <= '0;
      bus.Mem_Stall_Cnt <= '0;
    end else begin
      if ((|alu_gnt_c) && (bus.Alu_Issue_Cnt != '1))
        bus.Alu_Issue_Cnt <= bus.Alu_Issue_Cnt + CNT_W'(1);
      if ((|mem_gnt_c) && (bus.Mem_Issue_Cnt != '1))
        bus.Mem_Issue_Cnt <= bus.Mem_Issue_Cnt + CNT_W'(1);
      if ((|mem_cand_c) && !mem_allow_c && (bus.Mem_Stall_Cnt != '1))
        bus.Mem_Stall_Cnt <= bus.Mem_Stall_Cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ex_issue_arbiter.sv
module tb_ex_issue_arbiter;
  import ex_issue_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ex_issue_arbiter_if #(.CNT_W(CNT_W)) bus ();

  ex_issue_arbiter #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rdy, input logic [3:0] ism,
                       input logic stall, input logic done);
    bus.Ready_Ex  = rdy;
    bus.IsMem_Ex  = ism;
    bus.ALU_Stall = stall;
    bus.MEM_Done  = done;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    chk("rst_alu", 32'(bus.ALU_Grt), 32'h0);
    chk("rst_mem", 32'(bus.MEM_Grt), 32'h0);
    chk("rst_rel", 32'(bus.Release_Ex), 32'h0);
    chk("rst_busy", 32'(bus.Mem_Busy), 32'h0);
    rst = 1'b0;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Round-robin rotation over all four ALU entries.
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr_alu%0d", i), 32'(bus.ALU_Grt), 32'(rr_exp[i]));
      chk($sformatf("rr_rel%0d", i), 32'(bus.Release_Ex), 32'(rr_exp[i]));
    end
    chk("rr_mem", 32'(bus.MEM_Grt), 32'h0);

    // Simultaneous ALU and MEM grants.
    do_reset();
    drive(4'b0101, 4'b0100, 1'b0, 1'b0);
    step();
    chk("dual_alu", 32'(bus.ALU_Grt), 32'h1);
    chk("dual_mem", 32'(bus.MEM_Grt), 32'h4);
    chk("dual_rel", 32'(bus.Release_Ex), 32'h5);
    chk("dual_busy", 32'(bus.Mem_Busy), 32'h1);

    // MEM candidate blocked while busy, granted on MEM_Done.
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    step();
    chk("mask_mem", 32'(bus.MEM_Grt), 32'h0);
    chk("mask_busy", 32'(bus.Mem_Busy), 32'h1);
    step();
    chk("busy_mem", 32'(bus.MEM_Grt), 32'h0);
    bus.MEM_Done = 1'b1;
    step();
    bus.MEM_Done = 1'b0;
    chk("done_mem", 32'(bus.MEM_Grt), 32'h4);
    chk("done_busy", 32'(bus.Mem_Busy), 32'h1);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    chk("done_idle", 32'(bus.Mem_Busy), 32'h0);
    step();
    bus.MEM_Done = 1'b0;
    chk("idle_done_ign", 32'(bus.Mem_Busy), 32'h0);
    chk("idle_done_mem", 32'(bus.MEM_Grt), 32'h0);

    // ALU stall holds grants and pointer.
    do_reset();
    drive(4'b1000, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_alu%0d", i), 32'(bus.ALU_Grt), 32'h0);
    end
    bus.ALU_Stall = 1'b0;
    step();
    chk("unstall_alu", 32'(bus.ALU_Grt), 32'h8);
    bus.Ready_Ex = 4'b1111;
    step();
    chk("ptr_wrap0", 32'(bus.ALU_Grt), 32'h1);
    step();
    chk("ptr_wrap1", 32'(bus.ALU_Grt), 32'h2);

    // Asynchronous reset during MEM_BUSY abandons the operation.
    do_reset();
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    step();
    chk("arst_pre_busy", 32'(bus.Mem_Busy), 32'h1);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.Mem_Busy), 32'h0);
    chk("arst_mem", 32'(bus.MEM_Grt), 32'h0);
    chk("arst_rel", 32'(bus.Release_Ex), 32'h0);
    step();
    rst = 1'b0;
    bus.MEM_Done = 1'b1;
    step();
    bus.MEM_Done = 1'b0;
    chk("arst_done_busy", 32'(bus.Mem_Busy), 32'h0);
    chk("arst_done_mem", 32'(bus.MEM_Grt), 32'h0);
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    step();
    chk("arst_regrant", 32'(bus.MEM_Grt), 32'h4);
    chk("arst_regrant_busy", 32'(bus.Mem_Busy), 32'h1);

`ifdef ISSUE_PERF_CNT_EN
    // Performance counters: stall count and saturation.
    do_reset();
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) step();
    chk("cnt_mem_stall", 32'(bus.Mem_Stall_Cnt), 32'd5);
    chk("cnt_mem_issue", 32'(bus.Mem_Issue_Cnt), 32'd1);
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("cnt_alu_sat", 32'(bus.Alu_Issue_Cnt), 32'd15);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
